spi_slave_regbank_burst: RTL and testbench

Parametrised successor of the team's SPI slave: a multi-drop SPI target with a device-address match, a configurable register bank and a burst (auto-increment) mode. It sits on a shared mosi/sclk/cs bus. Several instances are distinguished by the strap pins addr. Register contents are exposed in parallel to the surrounding logic, and frames aborted by cs are counted.

---
 rtl/spi_slave_pkg.sv | 33 +++
 rtl/spi_slave_regbank_burst_regbank.sv | 38 +++
 rtl/spi_slave_regbank_burst.sv | 174 +++++++++++++++++
 tb/tb_spi_slave_regbank_burst.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave register bank family.
// Contents: FSM state encoding, frame field widths, abort counter width,
// and helpers that size the frame and the per-field bit counter.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEV,
    BRST,
    REG,
    DATA,
    SKIP
  } state_t;

  localparam int RW_BITS     = 1;
  localparam int BURST_BITS  = 1;
  localparam int ABORT_CNT_W = 8;

  // Total bits in a single-word frame.
  function automatic int frame_len(input int dw, input int dev_aw, input int reg_aw);
    return RW_BITS + dev_aw + BURST_BITS + reg_aw + dw;
  endfunction

  // The bit counter is reused for every field, so it is sized by the widest one.
  function automatic int cnt_width(input int dw, input int dev_aw, input int reg_aw);
    int m;
    m = dw;
    if (dev_aw > m) m = dev_aw;
    if (reg_aw > m) m = reg_aw;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/spi_slave_regbank_burst_regbank.sv
// spi_regbank: NREGS x DW register storage for the SPI slave.
// Ports: clk/rst (async active-low), we/widx/wdata write port,
// ridx/rdata combinational read port, regs_q flattened bank (reg i at [i*DW +: DW]).
module spi_regbank #(
  parameter int          DW      = 8,
  parameter int          REG_AW  = 3,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [REG_AW-1:0]          widx,
  input  logic [DW-1:0]              wdata,
  input  logic [REG_AW-1:0]          ridx,
  output logic [DW-1:0]              rdata,
  output logic [(2**REG_AW)*DW-1:0]  regs_q
);

  localparam int unsigned NREGS = 2**REG_AW;

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= RST_VAL;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

  always_comb begin
    regs_q = '0;
    for (int unsigned i = 0; i < NREGS; i++) regs_q[i*DW +: DW] = mem[i];
  end

endmodule

// File: rtl/spi_slave_regbank_burst.sv
// spi_slave_regbank_burst: multi-drop SPI target with device-address match,
// register bank and burst (auto-increment) mode.
// Ports: sclk (sole clock), rst (async active-low), cs (active-high), mosi,
// addr (strap), miso/miso_oe (registered), regs_q (flattened bank),
// wr_pulse/wr_idx (write strobe), abort_cnt (saturating aborted-frame count).
// Frame: RW, DEV (LSB first), BURST, REG (LSB first), DATA (MSB first).
module spi_slave_regbank_burst
  import spi_slave_pkg::*;
#(
  parameter int            DW      = 8,
  parameter int            DEV_AW  = 3,
  parameter int            REG_AW  = 3,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic                       sclk,
  input  logic                       rst,
  input  logic                       cs,
  input  logic                       mosi,
  input  logic [DEV_AW-1:0]          addr,
  output logic                       miso,
  output logic                       miso_oe,
  output logic [(2**REG_AW)*DW-1:0]  regs_q,
  output logic                       wr_pulse,
  output logic [REG_AW-1:0]          wr_idx,
  output logic [ABORT_CNT_W-1:0]     abort_cnt
);

  localparam int CW = cnt_width(DW, DEV_AW, REG_AW);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              rw;
  logic              burst;
  logic [DEV_AW-1:0] dev_sr;
  logic [REG_AW-1:0] idx;
  // Only DW-1 bits are held: the bit on mosi completes a write word, and on
  // reads the MSB goes straight to miso at load time.
  logic [DW-2:0]     sr;

  logic [DEV_AW-1:0] dev_nx;
  logic [REG_AW-1:0] idx_nx;
  logic [REG_AW-1:0] idx_inc;
  logic [REG_AW-1:0] ridx;
  logic [DW-1:0]     rdata;
  logic [DW-1:0]     wdata;
  logic              last_dev;
  logic              last_reg;
  logic              last_data;
  logic              we;
  logic              abort;

  always_comb begin
    dev_nx    = DEV_AW'({mosi, dev_sr} >> 1);
    idx_nx    = REG_AW'({mosi, idx} >> 1);
    idx_inc   = idx + REG_AW'(1);
    last_dev  = (cnt == CW'(DEV_AW - 1));
    last_reg  = (state == REG)  && (cnt == CW'(REG_AW - 1));
    last_data = (state == DATA) && (cnt == CW'(DW - 1));
    // Read index is the just-completed REG field, or the next one in a burst.
    ridx      = (state == REG) ? idx_nx : idx_inc;
    wdata     = {sr, mosi};
    we        = cs && rw && last_data;
    // Data state on a word boundary (cnt==0) is a clean end, not an abort.
    abort     = (state == DEV) || (state == BRST) || (state == REG) ||
                ((state == DATA) && (cnt != '0));
  end

  spi_regbank #(
    .DW      (DW),
    .REG_AW  (REG_AW),
    .RST_VAL (RST_VAL)
  ) u_regbank (
    .clk    (sclk),
    .rst    (rst),
    .we     (we),
    .widx   (idx),
    .wdata  (wdata),
    .ridx   (ridx),
    .rdata  (rdata),
    .regs_q (regs_q)
  );

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rw        <= 1'b0;
      burst     <= 1'b0;
      dev_sr    <= '0;
      idx       <= '0;
      sr        <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_idx    <= '0;
      abort_cnt <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (!cs) begin
        if (abort && (abort_cnt != '1)) abort_cnt <= abort_cnt + ABORT_CNT_W'(1);
        state   <= IDLE;
        cnt     <= '0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            rw    <= mosi;
            cnt   <= '0;
            state <= DEV;
          end
          DEV: begin
            dev_sr <= dev_nx;
            if (last_dev) begin
              cnt   <= '0;
              state <= (dev_nx == addr) ? BRST : SKIP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          BRST: begin
            burst <= mosi;
            cnt   <= '0;
            state <= REG;
          end
          REG: begin
            idx <= idx_nx;
            if (last_reg) begin
              cnt   <= '0;
              state <= DATA;
              if (!rw) begin
                sr      <= rdata[DW-2:0];
                miso    <= rdata[DW-1];
                miso_oe <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            sr <= wdata[DW-2:0];
            if (!rw) miso <= sr[DW-2];
            if (last_data) begin
              cnt <= '0;
              if (rw) begin
                wr_pulse <= 1'b1;
                wr_idx   <= idx;
              end
              if (burst) begin
                // Read bursts reload on the completing edge: no gap bit.
                idx <= idx_inc;
                if (!rw) begin
                  sr   <= rdata[DW-2:0];
                  miso <= rdata[DW-1];
                end
              end else begin
                state   <= SKIP;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          SKIP: begin
            miso_oe <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regbank_burst.sv
// Scoreboard bench for spi_slave_regbank_burst (DW=8, DEV_AW=3, REG_AW=3).
// Stimulus pushes expected write events and miso bits into queues; a monitor
// on the falling edge pops and compares whenever wr_pulse or miso_oe is high.
module tb_spi_slave_regbank_burst;

  localparam int DW     = 8;
  localparam int DEV_AW = 3;
  localparam int REG_AW = 3;
  localparam int NREGS  = 8;

  logic        sclk = 1'b0;
  logic        rst  = 1'b0;
  logic        cs   = 1'b0;
  logic        mosi = 1'b0;
  logic [2:0]  addr = 3'd7;
  logic        miso;
  logic        miso_oe;
  logic [NREGS*DW-1:0] regs_q;
  logic        wr_pulse;
  logic [2:0]  wr_idx;
  logic [7:0]  abort_cnt;

  spi_slave_regbank_burst #(
    .DW      (DW),
    .DEV_AW  (DEV_AW),
    .REG_AW  (REG_AW),
    .RST_VAL (8'h00)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .cs        (cs),
    .mosi      (mosi),
    .addr      (addr),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .regs_q    (regs_q),
    .wr_pulse  (wr_pulse),
    .wr_idx    (wr_idx),
    .abort_cnt (abort_cnt)
  );

  always #5 sclk = ~sclk;

  int errors = 0;
  int checks = 0;

  int         wq_idx [$];
  logic [7:0] wq_dat [$];
  logic       rq [$];
  logic [7:0] model [NREGS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are registered on the rising edge, so the falling edge
  // shows exactly what the master samples on the next rising edge.
  always @(negedge sclk) begin
    int ei;
    logic eb;
    if (wr_pulse === 1'b1) begin
      if (wq_idx.size() == 0) chk("wr_pulse_unexpected", {31'd0, wr_pulse}, 32'd0);
      else begin
        ei = wq_idx.pop_front();
        chk("wr_idx", {29'd0, wr_idx}, ei);
        chk("wr_data", {24'd0, regs_q[ei*8 +: 8]}, {24'd0, wq_dat.pop_front()});
      end
    end
    if (miso_oe === 1'b1) begin
      if (rq.size() == 0) chk("miso_oe_unexpected", {31'd0, miso_oe}, 32'd0);
      else begin
        eb = rq.pop_front();
        chk("miso_bit", {31'd0, miso}, {31'd0, eb});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    @(negedge sclk);
    cs   = 1'b1;
    mosi = b;
  endtask

  task automatic gap();
    @(negedge sclk);
    cs   = 1'b0;
    mosi = 1'b0;
    @(negedge sclk);
  endtask

  task automatic header(input logic rw, input logic [2:0] dev, input logic brst, input logic [2:0] r);
    send_bit(rw);
    for (int i = 0; i < 3; i++) send_bit(dev[i]);
    send_bit(brst);
    for (int i = 0; i < 3; i++) send_bit(r[i]);
  endtask

  task automatic send_byte(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic expect_write(input int idx, input logic [7:0] w);
    wq_idx.push_back(idx);
    wq_dat.push_back(w);
    model[idx] = w;
  endtask

  task automatic expect_read(input int idx);
    logic [7:0] v;
    v = model[idx];
    for (int i = 7; i >= 0; i--) rq.push_back(v[i]);
  endtask

  task automatic chk_regs(input string name);
    for (int i = 0; i < NREGS; i++) chk(name, {24'd0, regs_q[i*8 +: 8]}, {24'd0, model[i]});
  endtask

  initial begin
    logic [7:0] tmp;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge sclk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    chk("rst_wr_idx", {29'd0, wr_idx}, 32'd0);
    chk("rst_abort_cnt", {24'd0, abort_cnt}, 32'd0);
    chk_regs("rst_regs");
    rst = 1'b1;
    @(negedge sclk);

    // Single write: reg7 = 0xAD
    header(1'b1, 3'd7, 1'b0, 3'd7);
    expect_write(7, 8'hAD);
    send_byte(8'hAD);
    gap();
    chk("wr7_abort_cnt", {24'd0, abort_cnt}, 32'd0);
    chk_regs("wr7_regs");

    // Single read of reg7
    header(1'b0, 3'd7, 1'b0, 3'd7);
    expect_read(7);
    send_byte(8'h00);
    gap();
    chk("rd7_drained", rq.size(), 32'd0);
    chk("rd7_miso_oe_after", {31'd0, miso_oe}, 32'd0);

    // Address mismatch: nothing happens
    addr = 3'd5;
    header(1'b1, 3'd7, 1'b0, 3'd2);
    send_byte(8'h3C);
    gap();
    chk("mismatch_abort_cnt", {24'd0, abort_cnt}, 32'd0);
    chk_regs("mismatch_regs");
    addr = 3'd7;

    // Burst write from reg6 with wrap to reg0
    header(1'b1, 3'd7, 1'b1, 3'd6);
    expect_write(6, 8'h11); send_byte(8'h11);
    expect_write(7, 8'h22); send_byte(8'h22);
    expect_write(0, 8'h33); send_byte(8'h33);
    gap();
    chk("burst_wr_abort_cnt", {24'd0, abort_cnt}, 32'd0);
    chk_regs("burst_wr_regs");

    // Burst read reg6, reg7; the prefetched reg0 MSB shows before cs drops
    header(1'b0, 3'd7, 1'b1, 3'd6);
    expect_read(6);
    expect_read(7);
    tmp = model[0];
    rq.push_back(tmp[7]);
    send_byte(8'h00);
    send_byte(8'h00);
    gap();
    chk("burst_rd_drained", rq.size(), 32'd0);
    chk("burst_rd_abort_cnt", {24'd0, abort_cnt}, 32'd0);

    // Abort after 4 data bits of a write to reg2
    header(1'b1, 3'd7, 1'b0, 3'd2);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    gap();
    chk("abort1_cnt", {24'd0, abort_cnt}, 32'd1);
    chk_regs("abort1_regs");
    for (int n = 1; n < 300; n++) begin
      header(1'b1, 3'd7, 1'b0, 3'd2);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      gap();
    end
    chk("abort_sat_cnt", {24'd0, abort_cnt}, 32'd255);
    chk_regs("abort_sat_regs");

    // Reset mid-read
    header(1'b0, 3'd7, 1'b0, 3'd7);
    expect_read(7);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    @(posedge sclk);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    chk("midrst_miso", {31'd0, miso}, 32'd0);
    chk("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("midrst_abort_cnt", {24'd0, abort_cnt}, 32'd0);
    chk_regs("midrst_regs");
    rq.delete();
    cs   = 1'b0;
    mosi = 1'b0;
    @(negedge sclk);
    rst = 1'b1;
    @(negedge sclk);

    // Normal operation after reset
    header(1'b1, 3'd7, 1'b0, 3'd3);
    expect_write(3, 8'h5A);
    send_byte(8'h5A);
    gap();
    header(1'b0, 3'd7, 1'b0, 3'd3);
    expect_read(3);
    send_byte(8'h00);
    gap();
    chk_regs("post_rst_regs");
    chk("post_rst_abort_cnt", {24'd0, abort_cnt}, 32'd0);

    chk("wq_drained", wq_idx.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
